// File: rtl/rc4_stream_core_if.sv
// Keystream valid/ready bundle between the RC4 core and its consumer.
// master drives valid/data, slave drives ready.
interface rc4_stream_core_if #(
    parameter int DATA_W = 8
) ();
    logic              ks_valid;
    logic [DATA_W-1:0] ks_data;
    logic              ks_ready;

    modport master (
        output ks_valid,
        output ks_data,
        input  ks_ready
    );

    modport slave (
        input  ks_valid,
        input  ks_data,
        output ks_ready
    );
endinterface

// File: rtl/rc4_stream_core.sv
// RC4 core: S-box init, key scheduling and keystream with valid/ready output.
// Build macro RC4_DROP_EN inserts a DROP_N-word discard phase after KSA.
module rc4_stream_core #(
    parameter int DATA_W      = 8,
    parameter int KEY_LEN_MAX = 16,
    parameter int DROP_N      = 768
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           key_wr,
    input  logic [$clog2(KEY_LEN_MAX)-1:0] key_waddr,
    input  logic [DATA_W-1:0]              key_wdata,
    input  logic [$clog2(KEY_LEN_MAX):0]   key_len,
    input  logic                           start,
    output logic                           busy,
    output logic                           sched_done,
    output logic                           key_err,
    output logic [1:0]                     phase,
    rc4_stream_core_if.master              ks,
    output logic [15:0]                    ks_count
);
    localparam int KA = $clog2(KEY_LEN_MAX);

`ifdef RC4_DROP_EN
    localparam bit DROP_ON = (DROP_N > 0);
`else
    localparam bit DROP_ON = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_KSA, S_DROP, S_PRGA
    } state_t;

    state_t state_q, state_d;

    logic [DATA_W-1:0] sbox    [2**DATA_W];
    logic [DATA_W-1:0] key_mem [KEY_LEN_MAX];

    logic [DATA_W-1:0] i_q, j_q, rd_i, j_nx;
    logic [DATA_W-1:0] si, sj, st, t_idx, k_add, ks_word;
    logic [KA-1:0]     kidx_q;
    logic [KA:0]       klen_q;
    logic [15:0]       drop_q;
    logic [DATA_W-1:0] data_q;
    logic              valid_q, sched_q, err_q;
    logic              kick, key_bad, i_last, drop_last, step, enter_prga;

    assign key_bad   = (key_len == '0) || (key_len > (KA+1)'(KEY_LEN_MAX));
    assign kick      = start && (state_q == S_IDLE || state_q == S_PRGA);
    assign i_last    = &i_q;
    assign drop_last = (drop_q == 16'(DROP_N - 1));
    assign step      = !valid_q || ks.ks_ready;

    // KSA reads S[i]; PRGA/DROP read S[i+1]. Both share one swap path.
    assign rd_i    = (state_q == S_KSA) ? i_q : i_q + DATA_W'(1);
    assign k_add   = (state_q == S_KSA) ? key_mem[kidx_q] : '0;
    assign si      = sbox[rd_i];
    assign j_nx    = j_q + si + k_add;
    assign sj      = sbox[j_nx];
    assign t_idx   = si + sj;
    assign st      = sbox[t_idx];
    assign ks_word = (t_idx == rd_i) ? sj :
                     (t_idx == j_nx) ? si : st;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (kick) state_d = key_bad ? S_IDLE : S_INIT;
            S_INIT: if (i_last) state_d = S_KSA;
            S_KSA:  if (i_last) state_d = DROP_ON ? S_DROP : S_PRGA;
            S_DROP: if (drop_last) state_d = S_PRGA;
            S_PRGA: if (kick) state_d = key_bad ? S_IDLE : S_INIT;
            default: state_d = S_IDLE;
        endcase
    end

    assign enter_prga = (state_d == S_PRGA) && (state_q != S_PRGA);

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            i_q      <= '0;
            j_q      <= '0;
            kidx_q   <= '0;
            klen_q   <= '0;
            drop_q   <= '0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            sched_q  <= 1'b0;
            err_q    <= 1'b0;
            ks_count <= '0;
        end else begin
            sched_q <= enter_prga;
            if (enter_prga)
                ks_count <= '0;
            else if (valid_q && ks.ks_ready)
                ks_count <= ks_count + 16'd1;
            if (kick) begin
                valid_q <= 1'b0;
                i_q     <= '0;
                j_q     <= '0;
                kidx_q  <= '0;
                err_q   <= key_bad;
                if (!key_bad) klen_q <= key_len;
            end else begin
                unique case (state_q)
                    S_INIT: i_q <= i_q + DATA_W'(1);
                    S_KSA: begin
                        i_q    <= i_q + DATA_W'(1);
                        j_q    <= i_last ? '0 : j_nx;
                        drop_q <= '0;
                        kidx_q <= ({1'b0, kidx_q} == klen_q - (KA+1)'(1)) ?
                                  '0 : kidx_q + KA'(1);
                    end
                    S_DROP: begin
                        i_q    <= rd_i;
                        j_q    <= j_nx;
                        drop_q <= drop_q + 16'd1;
                    end
                    S_PRGA: if (step) begin
                        i_q     <= rd_i;
                        j_q     <= j_nx;
                        valid_q <= 1'b1;
                        data_q  <= ks_word;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == S_INIT) begin
            sbox[i_q] <= i_q;
        end else if (state_q == S_KSA || state_q == S_DROP ||
                     (state_q == S_PRGA && step && !kick)) begin
            sbox[rd_i] <= sj;
            sbox[j_nx] <= si;
        end
    end

    always_ff @(posedge clk) begin
        if (key_wr && (state_q == S_IDLE || state_q == S_PRGA))
            key_mem[key_waddr] <= key_wdata;
    end

    always_comb begin
        phase = 2'b00;
        busy  = 1'b0;
        unique case (state_q)
            S_INIT, S_KSA: begin phase = 2'b01; busy = 1'b1; end
            S_DROP:        begin phase = 2'b11; busy = 1'b1; end
            S_PRGA:        phase = 2'b10;
            default: ;
        endcase
    end

    assign sched_done  = sched_q;
    assign key_err     = err_q;
    assign ks.ks_valid = valid_q;
    assign ks.ks_data  = data_q;
endmodule

// File: tb/tb_rc4_stream_core.sv
// Self-checking bench for rc4_stream_core against a plain RC4 reference.
// Build with RC4_DROP_EN to exercise the 4-word drop configuration.
module tb_rc4_stream_core;
`ifdef RC4_DROP_EN
    localparam int TB_DROP = 4;
`else
    localparam int TB_DROP = 0;
`endif
    localparam int LAT = 513 + TB_DROP;

    logic        clk = 1'b0;
    logic        rst;
    logic        key_wr;
    logic [3:0]  key_waddr;
    logic [7:0]  key_wdata;
    logic [4:0]  key_len;
    logic        start;
    logic        busy, sched_done, key_err;
    logic [1:0]  phase;
    logic [15:0] ks_count;

    rc4_stream_core_if #(.DATA_W(8)) ks_if ();

    rc4_stream_core #(
        .DATA_W(8), .KEY_LEN_MAX(16), .DROP_N(4)
    ) dut (
        .clk(clk), .rst(rst),
        .key_wr(key_wr), .key_waddr(key_waddr), .key_wdata(key_wdata),
        .key_len(key_len), .start(start),
        .busy(busy), .sched_done(sched_done), .key_err(key_err),
        .phase(phase), .ks(ks_if), .ks_count(ks_count)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int acc = 0;
    logic [7:0] exp_q[$];
    bit         held_v = 1'b0;
    logic [7:0] held_d = '0;

    logic [7:0] k_key[$]  = '{8'h4B, 8'h65, 8'h79};
    logic [7:0] k_wiki[$] = '{8'h57, 8'h69, 8'h6B, 8'h69};
    logic [7:0] k_sec[$]  = '{8'h53, 8'h65, 8'h63, 8'h72, 8'h65, 8'h74};
    logic [7:0] r_key[10] = '{8'hEB, 8'h9F, 8'h77, 8'h81, 8'hB7,
                              8'h34, 8'hCA, 8'h72, 8'hA7, 8'h19};
    logic [7:0] r_wiki[6] = '{8'h60, 8'h44, 8'hDB, 8'h6D, 8'h41, 8'hB7};
    logic [7:0] r_sec[8]  = '{8'h04, 8'hD4, 8'h6B, 8'h05,
                              8'h3C, 8'hA8, 8'h7B, 8'h59};

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Textbook RC4 with an optional number of discarded leading words.
    task automatic model(input logic [7:0] k[$], input int n, input int drop,
                         output logic [7:0] out[$]);
        int s[256];
        int i, j, t;
        out = {};
        for (int x = 0; x < 256; x++) s[x] = x;
        j = 0;
        for (int x = 0; x < 256; x++) begin
            j = (j + s[x] + int'(k[x % k.size()])) % 256;
            t = s[x]; s[x] = s[j]; s[j] = t;
        end
        i = 0; j = 0;
        for (int x = 0; x < n + drop; x++) begin
            i = (i + 1) % 256;
            j = (j + s[i]) % 256;
            t = s[i]; s[i] = s[j]; s[j] = t;
            if (x >= drop) out.push_back(8'(s[(s[i] + s[j]) % 256]));
        end
    endtask

    always @(negedge clk) begin
        if (ks_if.ks_valid) begin
            if (held_v) check("stall_hold", ks_if.ks_data, held_d);
            if (ks_if.ks_ready) begin
                if (exp_q.size() == 0) check("exp_empty", 1, 0);
                else check("ks_word", ks_if.ks_data, exp_q.pop_front());
                acc++;
                held_v = 1'b0;
            end else begin
                held_v = 1'b1;
                held_d = ks_if.ks_data;
            end
        end else begin
            held_v = 1'b0;
        end
    end

    task automatic check_reset_vals();
        check("rst_busy", busy, 0);
        check("rst_sched", sched_done, 0);
        check("rst_keyerr", key_err, 0);
        check("rst_phase", phase, 0);
        check("rst_valid", ks_if.ks_valid, 0);
        check("rst_data", ks_if.ks_data, 0);
        check("rst_count", ks_count, 0);
    endtask

    task automatic load_key(input logic [7:0] k[$]);
        foreach (k[x]) begin
            key_wr = 1'b1;
            key_waddr = 4'(x);
            key_wdata = k[x];
            @(posedge clk); #1;
        end
        key_wr = 1'b0;
    endtask

    task automatic fill_exp(input logic [7:0] k[$]);
        logic [7:0] q[$];
        model(k, 40, TB_DROP, q);
        exp_q = q;
    endtask

    task automatic start_and_wait(input int len, input bit poke);
        int n, sd_cnt, sd_at;
        key_len = 5'(len);
        start = 1'b1;
        acc = 0;
        @(posedge clk); #1;
        start = 1'b0;
        check("valid_clear", ks_if.ks_valid, 0);
        check("busy_set", busy, 1);
        n = 0; sd_cnt = 0; sd_at = -1;
        while (n < 2000 && !ks_if.ks_valid) begin
            if (poke && n == 10) begin
                key_wr = 1'b1; key_waddr = 4'd0; key_wdata = 8'hFF;
            end
            if (n == 11) key_wr = 1'b0;
            @(posedge clk); n++; #1;
            if (sched_done) begin sd_cnt++; sd_at = n; end
            if (n == 100) check("phase_ksa", phase, 1);
        end
        key_wr = 1'b0;
        check("first_valid_latency", n, LAT);
        check("sched_done_at", sd_at, LAT - 1);
        check("sched_once", sd_cnt, 1);
        check("phase_prga", phase, 2);
        check("busy_clear", busy, 0);
        check("count_clear", ks_count, 0);
    endtask

    task automatic consume(input int n, input bit rnd);
        int cyc = 0;
        while (acc < n && cyc < 500) begin
            ks_if.ks_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk); #1;
            cyc++;
        end
        ks_if.ks_ready = 1'b0;
        check("consume_done", acc, n);
        check("ks_count", ks_count, n);
    endtask

    task automatic bad_start(input int len);
        key_len = 5'(len);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("bad_keyerr", key_err, 1);
        check("bad_phase", phase, 0);
        check("bad_busy", busy, 0);
        check("bad_valid", ks_if.ks_valid, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] q[$];
        rst = 1'b1; key_wr = 1'b0; key_waddr = '0; key_wdata = '0;
        key_len = '0; start = 1'b0; ks_if.ks_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_reset_vals();

        model(k_key, 10, 0, q);
        foreach (r_key[x]) check("model_key", q[x], r_key[x]);
        model(k_wiki, 6, 0, q);
        foreach (r_wiki[x]) check("model_wiki", q[x], r_wiki[x]);
        model(k_sec, 8, 0, q);
        foreach (r_sec[x]) check("model_secret", q[x], r_sec[x]);
        model(k_key, 1, 4, q);
        check("model_drop4", q[0], 8'hB7);

        load_key(k_key);
        fill_exp(k_key);
        start_and_wait(3, 1'b0);
        consume(10, 1'b0);

        key_len = 5'd3;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (300) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        check_reset_vals();
        load_key(k_key);
        fill_exp(k_key);
        start_and_wait(3, 1'b0);
        consume(10, 1'b0);

        bad_start(0);
        bad_start(17);
        load_key(k_wiki);
        fill_exp(k_wiki);
        start_and_wait(4, 1'b0);
        check("keyerr_cleared", key_err, 0);
        consume(6, 1'b1);

        load_key(k_sec);
        fill_exp(k_sec);
        start_and_wait(6, 1'b0);
        consume(8, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        load_key(k_key);
        fill_exp(k_key);
        start_and_wait(3, 1'b1);
        consume(10, 1'b1);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
